// File: rtl/md_seq_pkg.sv
// Shared types for the md_seq multiply/divide sequencer: operation codes and FSM states.
package md_seq_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_SIGN = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  function automatic logic op_is_div(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement on a pair of words: either as one wide value or as
// two independent halves. Used for operand abs on entry and result sign fixup.
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] val,
  input  logic           wide,
  input  logic           neg_hi,
  input  logic           neg_lo,
  output logic [2*W-1:0] res
);

  always_comb begin
    res = val;
    if (wide) begin
      // wide mode negates the full 2W-bit value, controlled by neg_lo alone
      if (neg_lo) res = -val;
    end else begin
      if (neg_hi) res[2*W-1:W] = -val[2*W-1:W];
      if (neg_lo) res[W-1:0]   = -val[W-1:0];
    end
  end

endmodule

// File: rtl/md_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; 32 shift-add or restoring steps.
// Optional macro MD_DIVZERO_FAST_EN: divide by zero completes straight from the accepting edge.
module md_seq
  import md_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       mdop_i,
  input  logic [WIDTH-1:0] srca_i,
  input  logic [WIDTH-1:0] srcb_i,
  input  logic             flush_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH);

  // Handshake: start_i is taken on an edge where busy_o=0 and flush_i=0; busy_o stays
  // high until results land, then done_o pulses for one cycle with HI/LO already valid.
  md_state_e        state, state_nx;
  md_op_e           op_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] w_hi, w_lo, w_b;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             neg_res, neg_rem;

  md_op_e           op_in;
  logic             in_signed, in_div, accept, dz_fast;
  logic [2*WIDTH-1:0] abs_ab, fixed;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign op_in     = md_op_e'(mdop_i);
  assign in_signed = op_is_signed(op_in);
  assign in_div    = op_is_div(op_in);
  assign busy_o    = (state == MD_CALC) || (state == MD_SIGN);
  assign done_o    = (state == MD_DONE);
  assign accept    = start_i && !flush_i && !busy_o;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;

`ifdef MD_DIVZERO_FAST_EN
  assign dz_fast = in_div && (srcb_i == '0);
`else
  assign dz_fast = 1'b0;
`endif

  md_sign_fix #(.W(WIDTH)) u_opnd_fix (
    .val    ({srca_i, srcb_i}),
    .wide   (1'b0),
    .neg_hi (in_signed && srca_i[WIDTH-1]),
    .neg_lo (in_signed && srcb_i[WIDTH-1]),
    .res    (abs_ab)
  );
  assign abs_a = abs_ab[2*WIDTH-1:WIDTH];
  assign abs_b = abs_ab[WIDTH-1:0];

  md_sign_fix #(.W(WIDTH)) u_res_fix (
    .val    ({w_hi, w_lo}),
    .wide   (!op_is_div(op_q)),
    .neg_hi (neg_rem),
    .neg_lo (neg_res),
    .res    (fixed)
  );

  // One iteration of either algorithm; w_hi is acc/remainder, w_lo is multiplier/quotient.
  logic [WIDTH:0]   mul_sum, div_sh;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             div_ge;

  always_comb begin
    mul_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_b} : '0);
    div_sh  = {w_hi, w_lo[WIDTH-1]};
    div_ge  = (div_sh >= {1'b0, w_b});
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], w_lo[WIDTH-1:1]};
    if (op_is_div(op_q)) begin
      step_hi = div_ge ? (div_sh[WIDTH-1:0] - w_b) : div_sh[WIDTH-1:0];
      step_lo = {w_lo[WIDTH-2:0], div_ge};
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      MD_IDLE, MD_DONE: begin
        state_nx = MD_IDLE;
        if (accept) state_nx = dz_fast ? MD_DONE : MD_CALC;
      end
      MD_CALC: if (cnt == CNT_W'(WIDTH - 1)) state_nx = MD_SIGN;
      MD_SIGN: state_nx = MD_DONE;
      default: state_nx = MD_IDLE;
    endcase
    if (flush_i) state_nx = MD_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= MD_MULT;
      cnt     <= '0;
      w_hi    <= '0;
      w_lo    <= '0;
      w_b     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (accept) begin
      op_q    <= op_in;
      cnt     <= '0;
      w_hi    <= '0;
      w_lo    <= in_div ? abs_a : abs_b;
      w_b     <= in_div ? abs_b : abs_a;
      neg_res <= in_signed && (srca_i[WIDTH-1] ^ srcb_i[WIDTH-1]);
      neg_rem <= in_signed && in_div && srca_i[WIDTH-1];
      if (dz_fast) begin
        // same values the full restoring sequence would produce for a zero divisor
        hi_q <= srca_i;
        lo_q <= (in_signed && srca_i[WIDTH-1]) ? WIDTH'(1) : '1;
      end
    end else if (!flush_i) begin
      if (state == MD_CALC) begin
        cnt  <= cnt + CNT_W'(1);
        w_hi <= step_hi;
        w_lo <= step_lo;
      end
      if (state == MD_SIGN) begin
        hi_q <= fixed[2*WIDTH-1:WIDTH];
        lo_q <= fixed[WIDTH-1:0];
      end
      if (!busy_o && mthi_i) hi_q <= wdata_i;
      if (!busy_o && mtlo_i) lo_q <= wdata_i;
    end
  end

endmodule

// File: tb/tb_md_seq.sv
// Directed and random checks of md_seq against a 64-bit arithmetic reference model.
module tb_md_seq;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

`ifdef MD_DIVZERO_FAST_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, flush_i, mthi_i, mtlo_i;
  logic [1:0]  mdop_i;
  logic [31:0] srca_i, srcb_i, wdata_i;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  int          lat_q[$];
  logic [31:0] mdl_hi = '0;
  logic [31:0] mdl_lo = '0;
  bit          last_fast;

  md_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .mdop_i  (mdop_i),
    .srca_i  (srca_i),
    .srcb_i  (srcb_i),
    .flush_i (flush_i),
    .mthi_i  (mthi_i),
    .mtlo_i  (mtlo_i),
    .wdata_i (wdata_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return ua * ub;
      OP_DIV: begin
        if (b == 32'd0) return {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic mthi);
    start_i   = 1'b1;
    mdop_i    = op;
    srca_i    = a;
    srcb_i    = b;
    mthi_i    = mthi;
    wdata_i   = 32'hDEAD_BEEF;
    last_fast = FAST_EN && op[1] && (b == 32'd0);
    exp_q.push_back(model(op, a, b));
    lat_q.push_back(last_fast ? 0 : 33);
  endtask

  task automatic accept_edge(input string tag);
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    mthi_i  = 1'b0;
    chk({tag, "_busy_acc"}, 64'(busy_o), 64'(!last_fast));
    if (!last_fast) begin
      chk({tag, "_hi_hold"}, 64'(hi_o), 64'(mdl_hi));
      chk({tag, "_lo_hold"}, 64'(lo_o), 64'(mdl_lo));
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    bit busy_ok = 1'b1;
    logic [63:0] e;
    int el;
    while (done_o !== 1'b1 && n < 200) begin
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    chk({tag, "_latency"}, 64'(n), 64'(el));
    chk({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
    chk({tag, "_hi"}, 64'(hi_o), 64'(e[63:32]));
    chk({tag, "_lo"}, 64'(lo_o), 64'(e[31:0]));
    mdl_hi = e[63:32];
    mdl_lo = e[31:0];
  endtask

  task automatic idle_after(input string tag);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_fall"}, 64'(done_o), 64'd0);
    chk({tag, "_busy_idle"}, 64'(busy_o), 64'd0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    @(negedge clk);
    drive_start(op, a, b, 1'b0);
    accept_edge(tag);
    wait_done(tag);
    idle_after(tag);
  endtask

  task automatic mt_write(input logic whi, input logic wlo, input logic [31:0] data, input string tag);
    @(negedge clk);
    mthi_i  = whi;
    mtlo_i  = wlo;
    wdata_i = data;
    @(posedge clk);
    @(negedge clk);
    mthi_i = 1'b0;
    mtlo_i = 1'b0;
    if (whi) mdl_hi = data;
    if (wlo) mdl_lo = data;
    chk({tag, "_hi"}, 64'(hi_o), 64'(mdl_hi));
    chk({tag, "_lo"}, 64'(lo_o), 64'(mdl_lo));
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    rst_n   = 1'b0;
    start_i = 1'b0;
    flush_i = 1'b0;
    mthi_i  = 1'b0;
    mtlo_i  = 1'b0;
    mdop_i  = 2'd0;
    srca_i  = '0;
    srcb_i  = '0;
    wdata_i = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(hi_o), 64'd0);
    chk("rst_lo", 64'(lo_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    rst_n = 1'b1;

    // directed arithmetic corners
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    chk("multu_max_hi_const", 64'(hi_o), 64'h0000_0000_FFFF_FFFE);
    chk("multu_max_lo_const", 64'(lo_o), 64'd1);
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, "mult_neg");
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
    run_op(OP_DIVU, 32'd7, 32'd0, "divu_zero");
    run_op(OP_DIV, 32'hFFFF_FFF8, 32'd0, "div_zero");
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(OP_DIV, 32'd100, 32'hFFFF_FFF9, "div_negb");

    // MTHI+MTLO together, then MTLO alone
    mt_write(1'b1, 1'b1, 32'h0000_5555, "mt_both");
    mt_write(1'b0, 1'b1, 32'h0000_1234, "mtlo");

    // flush at counter=10: no done, HI/LO untouched
    @(negedge clk);
    drive_start(OP_MULTU, 32'd3, 32'd4, 1'b0);
    accept_edge("flush");
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush_i = 1'b0;
    exp_q.delete();
    lat_q.delete();
    chk("flush_busy", 64'(busy_o), 64'd0);
    chk("flush_done", 64'(done_o), 64'd0);
    chk("flush_lo", 64'(lo_o), 64'h1234);
    chk("flush_hi", 64'(hi_o), 64'h5555);
    @(posedge clk);
    @(negedge clk);
    chk("flush_done_late", 64'(done_o), 64'd0);

    // start together with MTHI: op launches, HI not written on that edge
    @(negedge clk);
    drive_start(OP_MULTU, 32'd6, 32'd7, 1'b1);
    accept_edge("start_mthi");
    wait_done("start_mthi");
    idle_after("start_mthi");

    // back-to-back: second start held during DONE
    @(negedge clk);
    drive_start(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
    accept_edge("b2b1");
    wait_done("b2b1");
    drive_start(OP_DIVU, 32'hFFFF_FFFF, 32'd10, 1'b0);
    accept_edge("b2b2");
    wait_done("b2b2");
    idle_after("b2b2");

    // random operations
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: a = $urandom_range(0, 1000);
        default: ;
      endcase
      run_op(op, a, b, $sformatf("rnd%0d", i));
    end

    // asynchronous reset in the middle of CALC
    mt_write(1'b1, 1'b1, 32'hA5A5_A5A5, "pre_rst");
    @(negedge clk);
    drive_start(OP_MULTU, 32'h0001_2345, 32'h0000_6789, 1'b0);
    accept_edge("rst_mid");
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hi", 64'(hi_o), 64'd0);
    chk("arst_lo", 64'(lo_o), 64'd0);
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_done", 64'(done_o), 64'd0);
    exp_q.delete();
    lat_q.delete();
    mdl_hi = '0;
    mdl_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(OP_DIVU, 32'd100, 32'd7, "post_rst");
    chk("post_rst_lo_const", 64'(lo_o), 64'd14);
    chk("post_rst_hi_const", 64'(hi_o), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
